// File: rtl/alu_res_stat_if.sv
// Dispatch, CDB snoop, ALU-side output and status signals of the ALU
// reservation station. The station connects through the slave modport; the
// core side (dispatch/CDB/ALU) drives through the master modport.
interface alu_res_stat_if #(
  parameter int unsigned TAG_W = 5,
  parameter int unsigned DW    = 32,
  parameter int unsigned CTL_W = 4
);

  // Pipeline control
  logic             flush;

  // Dispatch request
  logic             disp_valid;
  logic [TAG_W-1:0] disp_tag;
  logic [CTL_W-1:0] disp_alu_ctl;
  logic             disp_op1_ready;
  logic [TAG_W-1:0] disp_op1_tag;
  logic [DW-1:0]    disp_op1_value;
  logic             disp_op2_ready;
  logic [TAG_W-1:0] disp_op2_tag;
  logic [DW-1:0]    disp_op2_value;

  // Common data bus snoop
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [DW-1:0]    cdb_data;

  // Issue port towards the ALU (alu_res_stat_output_ifc)
  logic             alu_ready;
  logic             out_valid;
  logic [TAG_W-1:0] out_tag;
  logic [CTL_W-1:0] out_alu_ctl;
  logic [DW-1:0]    out_op1;
  logic [DW-1:0]    out_op2;

  // Status (alu_res_stat_status_ifc)
  logic             full;

  modport master (
    output flush,
    output disp_valid, disp_tag, disp_alu_ctl,
    output disp_op1_ready, disp_op1_tag, disp_op1_value,
    output disp_op2_ready, disp_op2_tag, disp_op2_value,
    output cdb_valid, cdb_tag, cdb_data,
    output alu_ready,
    input  out_valid, out_tag, out_alu_ctl, out_op1, out_op2,
    input  full
  );

  modport slave (
    input  flush,
    input  disp_valid, disp_tag, disp_alu_ctl,
    input  disp_op1_ready, disp_op1_tag, disp_op1_value,
    input  disp_op2_ready, disp_op2_tag, disp_op2_value,
    input  cdb_valid, cdb_tag, cdb_data,
    input  alu_ready,
    output out_valid, out_tag, out_alu_ctl, out_op1, out_op2,
    output full
  );

endinterface

// File: rtl/alu_res_stat.sv
// ALU reservation station: collapsing queue of DEPTH ops (entry 0 oldest),
// CDB wake-up, oldest-ready select and a registered issue port.
module alu_res_stat #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 5,
  parameter int unsigned DW    = 32,
  parameter int unsigned CTL_W = 4
) (
  input logic           clk,
  input logic           rst,
  alu_res_stat_if.slave io
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [CTL_W-1:0] alu_ctl;
    logic             op1_rdy;
    logic [TAG_W-1:0] op1_tag;
    logic [DW-1:0]    op1_val;
    logic             op2_rdy;
    logic [TAG_W-1:0] op2_tag;
    logic [DW-1:0]    op2_val;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;

  logic             out_valid_q, out_valid_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [CTL_W-1:0] out_alu_ctl_q, out_alu_ctl_d;
  logic [DW-1:0]    out_op1_q, out_op1_d;
  logic [DW-1:0]    out_op2_q, out_op2_d;

  entry_t           woke [DEPTH];
  entry_t           above [DEPTH];
  entry_t           disp_ent;
  logic             sel_found;
  logic [IW-1:0]    sel_idx;
  logic             can_load;
  logic             do_issue;
  logic             do_disp;
  logic [CW-1:0]    disp_idx;

  // Oldest entry whose stored (pre-edge) operands are both ready
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!sel_found && (CW'(i) < count_q) && ent_q[i].op1_rdy && ent_q[i].op2_rdy) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  // Handshake decisions for this cycle
  always_comb begin
    can_load = !out_valid_q || io.alu_ready;
    do_issue = can_load && sel_found;
    do_disp  = io.disp_valid && !full_q;
    disp_idx = count_q - CW'(do_issue);
  end

  // CDB wake-up applied to every stored entry
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      woke[i] = ent_q[i];
      if (io.cdb_valid && !ent_q[i].op1_rdy && (ent_q[i].op1_tag == io.cdb_tag)) begin
        woke[i].op1_rdy = 1'b1;
        woke[i].op1_val = io.cdb_data;
      end
      if (io.cdb_valid && !ent_q[i].op2_rdy && (ent_q[i].op2_tag == io.cdb_tag)) begin
        woke[i].op2_rdy = 1'b1;
        woke[i].op2_val = io.cdb_data;
      end
    end
  end

  // Incoming op, with same-cycle CDB bypass for missing operands
  always_comb begin
    disp_ent.tag     = io.disp_tag;
    disp_ent.alu_ctl = io.disp_alu_ctl;
    disp_ent.op1_rdy = io.disp_op1_ready;
    disp_ent.op1_tag = io.disp_op1_tag;
    disp_ent.op1_val = io.disp_op1_value;
    disp_ent.op2_rdy = io.disp_op2_ready;
    disp_ent.op2_tag = io.disp_op2_tag;
    disp_ent.op2_val = io.disp_op2_value;
    if (io.cdb_valid && !io.disp_op1_ready && (io.disp_op1_tag == io.cdb_tag)) begin
      disp_ent.op1_rdy = 1'b1;
      disp_ent.op1_val = io.cdb_data;
    end
    if (io.cdb_valid && !io.disp_op2_ready && (io.disp_op2_tag == io.cdb_tag)) begin
      disp_ent.op2_rdy = 1'b1;
      disp_ent.op2_val = io.cdb_data;
    end
  end

  // Woken entries viewed one slot down, used to close the hole left by an issue
  always_comb begin
    for (int unsigned j = 0; j + 1 < DEPTH; j++) begin
      above[j] = woke[j + 1];
    end
    above[DEPTH-1] = '0;
  end

  // Next queue contents: collapse over the issued slot, then append the dispatch
  always_comb begin
    for (int unsigned j = 0; j < DEPTH; j++) begin
      if (do_issue && (CW'(j) >= {1'b0, sel_idx})) begin
        ent_d[j] = above[j];
      end else begin
        ent_d[j] = woke[j];
      end
      if (do_disp && (CW'(j) == disp_idx)) begin
        ent_d[j] = disp_ent;
      end
      if (io.flush) begin
        ent_d[j] = '0;
      end
    end
  end

  // Occupancy and registered full flag
  always_comb begin
    count_d = count_q + CW'(do_disp) - CW'(do_issue);
    if (io.flush) begin
      count_d = '0;
    end
    full_d = (count_d == CW'(DEPTH));
  end

  // Output register: load on issue, drain when accepted with nothing to send
  always_comb begin
    out_valid_d   = out_valid_q;
    out_tag_d     = out_tag_q;
    out_alu_ctl_d = out_alu_ctl_q;
    out_op1_d     = out_op1_q;
    out_op2_d     = out_op2_q;
    if (do_issue) begin
      out_valid_d   = 1'b1;
      out_tag_d     = ent_q[sel_idx].tag;
      out_alu_ctl_d = ent_q[sel_idx].alu_ctl;
      out_op1_d     = ent_q[sel_idx].op1_val;
      out_op2_d     = ent_q[sel_idx].op2_val;
    end else if (can_load && io.alu_ready) begin
      out_valid_d = 1'b0;
    end
    if (io.flush) begin
      out_valid_d   = 1'b0;
      out_tag_d     = '0;
      out_alu_ctl_d = '0;
      out_op1_d     = '0;
      out_op2_d     = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        ent_q[j] <= '0;
      end
      count_q       <= '0;
      full_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_tag_q     <= '0;
      out_alu_ctl_q <= '0;
      out_op1_q     <= '0;
      out_op2_q     <= '0;
    end else begin
      for (int unsigned j = 0; j < DEPTH; j++) begin
        ent_q[j] <= ent_d[j];
      end
      count_q       <= count_d;
      full_q        <= full_d;
      out_valid_q   <= out_valid_d;
      out_tag_q     <= out_tag_d;
      out_alu_ctl_q <= out_alu_ctl_d;
      out_op1_q     <= out_op1_d;
      out_op2_q     <= out_op2_d;
    end
  end

  assign io.out_valid   = out_valid_q;
  assign io.out_tag     = out_tag_q;
  assign io.out_alu_ctl = out_alu_ctl_q;
  assign io.out_op1     = out_op1_q;
  assign io.out_op2     = out_op2_q;
  assign io.full        = full_q;

endmodule
